pe_alu: RTL and testbench
=========================

# pe_alu

Two-stage pipelined 32-bit function unit of the PE tile. It consumes the switch matrix operand outputs `data_in1`, `data_in2` and `data_in3`, and produces `data_out`. `data_out` is routed back through the switch matrix to the external RES register and to the tile outputs. The operation is chosen statically by configuration bits; operand validity is tracked with a single valid bit so downstream logic knows when `data_out` carries a fresh result.

## Interface
Parameters:
- `NoConfigBits`, default 5: number of configuration bits.
  - [3:0] opcode.
  - [4] signed mode.

Ports:
- `UserCLK`, input, 1: clock; all state updates on the rising edge.
- `RST`, input, 1: asynchronous, active-high reset.
- `data_in1`, input, 32: operand A.
- `data_in2`, input, 32: operand B.
- `data_in3`, input, 32: operand C (addend or select).
- `in_valid`, input, 1: operands valid this cycle.
- `ConfigBits`, input, NoConfigBits: opcode and signed mode. Static during operation.
- `data_out`, output, 32: result register.
- `out_valid`, output, 1: `data_out` was updated on the last edge.

## Operation
- Opcodes, with A = `data_in1`, B = `data_in2`, C = `data_in3`, S = signed mode:
  - 0 PASS: result is A.
  - 1 ADD: A+B.
  - 2 SUB: A−B.
  - 3 AND, 4 OR, 5 XOR: bitwise A op B.
  - 6 SHL: A << B[4:0].
  - 7 SHR: A >> B[4:0]; logical when S=0, arithmetic when S=1.
  - 8 MUL: low 32 bits of A*B.
  - 9 MULH: high 32 bits of A*B; operands signed when S=1.
  - 10 MAC: low 32 bits of (A*B + C).
  - 11 LT: result is 32'd1 if A<B, else 32'd0; signed compare when S=1.
  - 12 EQ: 32'd1 if A==B, else 32'd0.
  - 13 SEL: C[0] ? A : B.
  - 14 ACC: `data_out` + A. Uses the current `data_out` value.
  - 15 MAX: the larger of A and B; signed compare when S=1.
- All add, subtract and multiply arithmetic wraps modulo 2^32, except MULH. No flags, no saturation.
- Stage 1 (sampled when `in_valid`=1):
  - Registers A, B, C, opcode, S and the full 64-bit product.
  - Sets `s1_valid`.
  - When `in_valid`=0, `s1_valid` clears and the stage-1 data registers hold.
- Stage 2 (when `s1_valid`=1):
  - Computes the final result from the stage-1 registers and writes `data_out`.
  - `out_valid` = registered `s1_valid`.
  - When `s1_valid`=0, `data_out` holds its previous value.
- ACC accumulates across back-to-back valid inputs with no forwarding hazard. The accumulator is `data_out` itself, which updates every valid stage-2 cycle.
- To load the accumulator, issue PASS; to clear it, issue PASS with A=0.
- Opcode and S travel with the data. A `ConfigBits` change affects only operands sampled after the change; in-flight operations complete with their own opcode.

## Timing
- Reset values: `data_out`=32'd0, `out_valid`=0, and all stage-1 registers 0.
- Reset takes effect immediately and asynchronously. Reset mid-operation discards in-flight results; there are no spurious `out_valid` pulses after release.
- Latency is fixed at 2 cycles for every opcode. With `in_valid` high at edge k, `out_valid`=1 and the result appear after edge k+1.
- Throughput is 1 operation per cycle. There is no backpressure and no stall input; the static schedule guarantees consumption.
- `in_valid` gaps propagate as `out_valid`=0 cycles. `data_out` stays stable across gaps.
- ACC after a gap uses the last valid `data_out`, regardless of the gap length.

## Structure
- `pe_pkg` holds:
  - Opcode localparams `OP_PASS` through `OP_MAX`.
  - `PE_WIDTH`=32.
  - The ConfigBits field offsets.
- Sub-module `pe_mul32`: combinational 32x32→64 multiplier with a signed-mode input, instantiated in stage 1. It isolates the multiplier for tech mapping.
- The remainder, pipeline registers and stage-2 result mux, lives in `pe_alu`.

## Test plan
- Reset, then ADD: A=5, B=7 with `in_valid` pulsed once → exactly one `out_valid` pulse, 2 cycles later, with `data_out`=12; 12 holds afterwards.
- Signed operations, S=1:
  - MULH with A=0xFFFFFFFF, B=2 → 0xFFFFFFFF.
  - With S=0 → 0x00000001.
  - SHR with A=0x80000000, B=4 → 0xF8000000 (S=1) and 0x08000000 (S=0).
- ACC stream: PASS A=10, then ACC A=1,2,3 on consecutive cycles → `data_out` reads 10, 11, 13, 16 on consecutive cycles. After a 3-cycle gap, ACC A=4 → 20.
- Opcode switch mid-stream: ADD (3,4) followed next cycle by SUB (3,4) after a `ConfigBits` change → outputs 7 then 0xFFFFFFFF; each op uses its own opcode.
- Compare and select:
  - LT with A=0xFFFFFFFF, B=1 → 1 when S=1, 0 when S=0.
  - SEL with C=1 → A.
  - MAC (3,4,5) → 17.
- Assert `RST` one cycle after an ADD issue → `out_valid` never rises for that op; `data_out`=0 until the next valid op completes.

Source files
------------

// File: rtl/pe_pkg.sv
// Shared constants for the PE tile function unit: datapath width, opcodes and
// ConfigBits field layout.
package pe_pkg;

  localparam int PE_WIDTH = 32;

  localparam int CFG_OP_LSB = 0;
  localparam int CFG_OP_W   = 4;
  localparam int CFG_S_BIT  = 4;

  localparam logic [3:0] OP_PASS = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_AND  = 4'd3;
  localparam logic [3:0] OP_OR   = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_SHL  = 4'd6;
  localparam logic [3:0] OP_SHR  = 4'd7;
  localparam logic [3:0] OP_MUL  = 4'd8;
  localparam logic [3:0] OP_MULH = 4'd9;
  localparam logic [3:0] OP_MAC  = 4'd10;
  localparam logic [3:0] OP_LT   = 4'd11;
  localparam logic [3:0] OP_EQ   = 4'd12;
  localparam logic [3:0] OP_SEL  = 4'd13;
  localparam logic [3:0] OP_ACC  = 4'd14;
  localparam logic [3:0] OP_MAX  = 4'd15;

endpackage

// File: rtl/pe_mul32.sv
// Combinational 32x32 -> 64 multiplier, kept in its own module so synthesis can
// map it onto a hard multiplier block.
module pe_mul32
  import pe_pkg::*;
(
  input  logic [PE_WIDTH-1:0]   a_i,
  input  logic [PE_WIDTH-1:0]   b_i,
  input  logic                  signed_i,
  output logic [2*PE_WIDTH-1:0] p_o
);

  logic signed [2*PE_WIDTH-1:0] p_s;
  logic        [2*PE_WIDTH-1:0] p_u;

  // Operands widened explicitly so the 64-bit product is exact in both modes.
  assign p_s = $signed({{PE_WIDTH{a_i[PE_WIDTH-1]}}, a_i}) *
               $signed({{PE_WIDTH{b_i[PE_WIDTH-1]}}, b_i});
  assign p_u = {{PE_WIDTH{1'b0}}, a_i} * {{PE_WIDTH{1'b0}}, b_i};
  assign p_o = signed_i ? p_s : p_u;

endmodule

// File: rtl/pe_alu.sv
// Two-stage pipelined 32-bit PE function unit: stage 1 captures operands,
// config and the full product; stage 2 selects the result into data_out.
module pe_alu
  import pe_pkg::*;
#(
  parameter int NoConfigBits = 5
) (
  input  logic                    UserCLK,
  input  logic                    RST,
  input  logic [PE_WIDTH-1:0]     data_in1,
  input  logic [PE_WIDTH-1:0]     data_in2,
  input  logic [PE_WIDTH-1:0]     data_in3,
  input  logic                    in_valid,
  input  logic [NoConfigBits-1:0] ConfigBits,
  output logic [PE_WIDTH-1:0]     data_out,
  output logic                    out_valid
);

  logic [3:0]            cfg_op;
  logic                  cfg_s;
  logic [2*PE_WIDTH-1:0] prod_d;

  logic [PE_WIDTH-1:0]   a_q, b_q, c_q;
  logic [3:0]            op_q;
  logic                  s_q;
  logic [2*PE_WIDTH-1:0] prod_q;
  logic                  s1_valid_q;

  logic [PE_WIDTH-1:0]   data_out_q, result_d;
  logic                  out_valid_q;

  assign cfg_op = ConfigBits[CFG_OP_LSB +: CFG_OP_W];
  assign cfg_s  = ConfigBits[CFG_S_BIT];

  pe_mul32 u_mul (
    .a_i      (data_in1),
    .b_i      (data_in2),
    .signed_i (cfg_s),
    .p_o      (prod_d)
  );

  // Opcode and signed mode are captured with the operands so a config change
  // never affects an operation already in flight.
  always_ff @(posedge UserCLK or posedge RST) begin
    if (RST) begin
      a_q        <= '0;
      b_q        <= '0;
      c_q        <= '0;
      op_q       <= OP_PASS;
      s_q        <= 1'b0;
      prod_q     <= '0;
      s1_valid_q <= 1'b0;
    end else begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        a_q    <= data_in1;
        b_q    <= data_in2;
        c_q    <= data_in3;
        op_q   <= cfg_op;
        s_q    <= cfg_s;
        prod_q <= prod_d;
      end
    end
  end

  logic                lt;
  logic [PE_WIDTH-1:0] sra;

  assign lt  = s_q ? ($signed(a_q) < $signed(b_q)) : (a_q < b_q);
  assign sra = $signed(a_q) >>> b_q[4:0];

  always_comb begin
    result_d = a_q;
    unique case (op_q)
      OP_PASS: result_d = a_q;
      OP_ADD:  result_d = a_q + b_q;
      OP_SUB:  result_d = a_q - b_q;
      OP_AND:  result_d = a_q & b_q;
      OP_OR:   result_d = a_q | b_q;
      OP_XOR:  result_d = a_q ^ b_q;
      OP_SHL:  result_d = a_q << b_q[4:0];
      OP_SHR:  result_d = s_q ? sra : (a_q >> b_q[4:0]);
      OP_MUL:  result_d = prod_q[PE_WIDTH-1:0];
      OP_MULH: result_d = prod_q[2*PE_WIDTH-1:PE_WIDTH];
      OP_MAC:  result_d = prod_q[PE_WIDTH-1:0] + c_q;
      OP_LT:   result_d = {{(PE_WIDTH-1){1'b0}}, lt};
      OP_EQ:   result_d = {{(PE_WIDTH-1){1'b0}}, (a_q == b_q)};
      OP_SEL:  result_d = c_q[0] ? a_q : b_q;
      // The accumulator is data_out itself, so back-to-back ACCs chain directly.
      OP_ACC:  result_d = data_out_q + a_q;
      OP_MAX:  result_d = lt ? b_q : a_q;
      default: result_d = a_q;
    endcase
  end

  always_ff @(posedge UserCLK or posedge RST) begin
    if (RST) begin
      data_out_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) data_out_q <= result_d;
    end
  end

  assign data_out  = data_out_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_pe_alu.sv
// Directed bench for pe_alu: a table of single-issue vectors plus hand-written
// sequences for latency, accumulate chaining, config switching and reset.
module tb_pe_alu;

  logic        UserCLK = 1'b0;
  logic        RST;
  logic [31:0] data_in1, data_in2, data_in3;
  logic        in_valid;
  logic [4:0]  ConfigBits;
  logic [31:0] data_out;
  logic        out_valid;

  int total = 0;
  int passed = 0;

  pe_alu #(.NoConfigBits(5)) dut (
    .UserCLK    (UserCLK),
    .RST        (RST),
    .data_in1   (data_in1),
    .data_in2   (data_in2),
    .data_in3   (data_in3),
    .in_valid   (in_valid),
    .ConfigBits (ConfigBits),
    .data_out   (data_out),
    .out_valid  (out_valid)
  );

  always #5 UserCLK = ~UserCLK;

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic        s;
    logic [31:0] a, b, c;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic drive(input logic v, input logic [3:0] op, input logic s,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    in_valid   = v;
    ConfigBits = {s, op};
    data_in1   = a;
    data_in2   = b;
    data_in3   = c;
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic add_vec(input string n, input logic [3:0] op, input logic s,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                         input logic [31:0] exp);
    vec_t v;
    v.name = n; v.op = op; v.s = s; v.a = a; v.b = b; v.c = c; v.exp = exp;
    vecs.push_back(v);
  endtask

  initial begin
    add_vec("pass",      4'd0,  1'b0, 32'h0000_1234, 32'h0,         32'h0, 32'h0000_1234);
    add_vec("add_wrap",  4'd1,  1'b0, 32'hFFFF_FFFF, 32'h2,         32'h0, 32'h0000_0001);
    add_vec("and",       4'd3,  1'b0, 32'h0000_F0F0, 32'h0000_FF00, 32'h0, 32'h0000_F000);
    add_vec("or",        4'd4,  1'b0, 32'h0000_F0F0, 32'h0000_FF00, 32'h0, 32'h0000_FFF0);
    add_vec("xor",       4'd5,  1'b0, 32'h0000_F0F0, 32'h0000_FF00, 32'h0, 32'h0000_0FF0);
    add_vec("shl_b5",    4'd6,  1'b0, 32'h0000_0001, 32'h0000_003F, 32'h0, 32'h8000_0000);
    add_vec("shr_s1",    4'd7,  1'b1, 32'h8000_0000, 32'h4,         32'h0, 32'hF800_0000);
    add_vec("shr_s0",    4'd7,  1'b0, 32'h8000_0000, 32'h4,         32'h0, 32'h0800_0000);
    add_vec("mul",       4'd8,  1'b0, 32'd7,         32'd6,         32'h0, 32'd42);
    add_vec("mul_wrap",  4'd8,  1'b0, 32'h0001_0000, 32'h0001_0000, 32'h0, 32'h0);
    add_vec("mulh_s1",   4'd9,  1'b1, 32'hFFFF_FFFF, 32'h2,         32'h0, 32'hFFFF_FFFF);
    add_vec("mulh_s0",   4'd9,  1'b0, 32'hFFFF_FFFF, 32'h2,         32'h0, 32'h0000_0001);
    add_vec("mac",       4'd10, 1'b0, 32'd3,         32'd4,         32'd5, 32'd17);
    add_vec("lt_s1",     4'd11, 1'b1, 32'hFFFF_FFFF, 32'h1,         32'h0, 32'd1);
    add_vec("lt_s0",     4'd11, 1'b0, 32'hFFFF_FFFF, 32'h1,         32'h0, 32'd0);
    add_vec("eq_t",      4'd12, 1'b0, 32'd9,         32'd9,         32'h0, 32'd1);
    add_vec("eq_f",      4'd12, 1'b0, 32'd9,         32'd8,         32'h0, 32'd0);
    add_vec("sel_a",     4'd13, 1'b0, 32'hAAAA_0001, 32'hBBBB_0002, 32'd1, 32'hAAAA_0001);
    add_vec("sel_b",     4'd13, 1'b0, 32'hAAAA_0001, 32'hBBBB_0002, 32'd2, 32'hBBBB_0002);
    add_vec("max_s1",    4'd15, 1'b1, 32'hFFFF_FFFF, 32'h1,         32'h0, 32'h0000_0001);
    add_vec("max_s0",    4'd15, 1'b0, 32'hFFFF_FFFF, 32'h1,         32'h0, 32'hFFFF_FFFF);

    RST = 1'b1;
    drive(1'b0, 4'd0, 1'b0, 32'h0, 32'h0, 32'h0);
    repeat (2) @(negedge UserCLK);
    chk("rst_data", data_out, 32'h0);
    chk("rst_valid", {31'h0, out_valid}, 32'h0);
    RST = 1'b0;

    // Single ADD: one out_valid pulse exactly two edges after issue, then hold.
    @(negedge UserCLK);
    drive(1'b1, 4'd1, 1'b0, 32'd5, 32'd7, 32'd0);
    @(negedge UserCLK);
    idle();
    chk("add_lat1_valid", {31'h0, out_valid}, 32'h0);
    @(negedge UserCLK);
    chk("add_valid", {31'h0, out_valid}, 32'h1);
    chk("add_data", data_out, 32'd12);
    repeat (3) begin
      @(negedge UserCLK);
      chk("add_hold_valid", {31'h0, out_valid}, 32'h0);
      chk("add_hold_data", data_out, 32'd12);
    end

    foreach (vecs[i]) begin
      drive(1'b1, vecs[i].op, vecs[i].s, vecs[i].a, vecs[i].b, vecs[i].c);
      @(negedge UserCLK);
      idle();
      @(negedge UserCLK);
      chk({vecs[i].name, "_valid"}, {31'h0, out_valid}, 32'h1);
      chk(vecs[i].name, data_out, vecs[i].exp);
    end
    @(negedge UserCLK);

    // ACC chain: PASS 10, ACC 1,2,3 back-to-back, gap, ACC 4.
    begin
      logic [31:0] acc_a[4];
      logic [31:0] acc_e[4];
      acc_a = '{32'd10, 32'd1, 32'd2, 32'd3};
      acc_e = '{32'd10, 32'd11, 32'd13, 32'd16};
      for (int i = 0; i < 6; i++) begin
        if (i >= 2) begin
          chk("acc_valid", {31'h0, out_valid}, 32'h1);
          chk("acc_data", data_out, acc_e[i-2]);
        end
        if (i < 4) drive(1'b1, (i == 0) ? 4'd0 : 4'd14, 1'b0, acc_a[i], 32'h0, 32'h0);
        else idle();
        @(negedge UserCLK);
      end
    end
    repeat (2) begin
      chk("gap_valid", {31'h0, out_valid}, 32'h0);
      chk("gap_data", data_out, 32'd16);
      @(negedge UserCLK);
    end
    drive(1'b1, 4'd14, 1'b0, 32'd4, 32'h0, 32'h0);
    @(negedge UserCLK);
    idle();
    @(negedge UserCLK);
    chk("acc_gap", data_out, 32'd20);
    chk("acc_gap_valid", {31'h0, out_valid}, 32'h1);

    // Config switch between back-to-back ops.
    drive(1'b1, 4'd1, 1'b0, 32'd3, 32'd4, 32'd0);
    @(negedge UserCLK);
    drive(1'b1, 4'd2, 1'b0, 32'd3, 32'd4, 32'd0);
    @(negedge UserCLK);
    idle();
    chk("sw_add", data_out, 32'd7);
    @(negedge UserCLK);
    chk("sw_sub", data_out, 32'hFFFF_FFFF);
    chk("sw_sub_valid", {31'h0, out_valid}, 32'h1);
    @(negedge UserCLK);

    // Reset one cycle after an ADD issue discards it.
    drive(1'b1, 4'd1, 1'b0, 32'd100, 32'd1, 32'd0);
    @(negedge UserCLK);
    idle();
    RST = 1'b1;
    #1;
    chk("rst_async_data", data_out, 32'h0);
    @(negedge UserCLK);
    RST = 1'b0;
    repeat (3) begin
      @(negedge UserCLK);
      chk("rst_mid_valid", {31'h0, out_valid}, 32'h0);
      chk("rst_mid_data", data_out, 32'h0);
    end
    drive(1'b1, 4'd1, 1'b0, 32'd2, 32'd3, 32'd0);
    @(negedge UserCLK);
    idle();
    @(negedge UserCLK);
    chk("post_rst_add", data_out, 32'd5);
    chk("post_rst_valid", {31'h0, out_valid}, 32'h1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
